// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter; drop-in replacement for the fixed-pattern detector.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clock_i,
  input  logic               sreset_ni,
  input  logic               in_i,
  input  logic               valid_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  input  logic               cnt_clr_i,
  output logic               out_o,
  output logic [CNT_W-1:0]   match_cnt_o
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Only MAX_LEN-1 past bits are stored: together with the incoming bit they
  // form the full MAX_LEN-bit window, and the oldest bit is never compared.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               out_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               accept;
  logic               match;

  always_comb begin
    hist_shift  = {hist_q, in_i};
    fill_inc    = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
    len_clamped = (len_i > MAX_LEN_L) ? MAX_LEN_L : len_i;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    accept = valid_i && !cfg_load_i;
    match  = accept && (len_q != '0) && (fill_inc >= len_q) &&
             ((hist_shift & len_mask) == (pat_q & len_mask));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (!sreset_ni) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q <= match;

      // Clear has priority over a coincident match increment.
      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (cfg_load_i) begin
        pat_q  <= pattern_i;
        len_q  <= len_clamped;
        ovl_q  <= overlap_i;
        hist_q <= '0;
        fill_q <= '0;
      end else if (valid_i) begin
        hist_q <= hist_shift[MAX_LEN-2:0];
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
      end
    end
  end

  assign out_o       = out_q;
  assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param; a second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_bit;
  logic               valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               cnt_clr;
  logic               out_a, out_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clock_i(clk), .sreset_ni(rst_n), .in_i(in_bit), .valid_i(valid),
    .cfg_load_i(cfg_load), .pattern_i(pattern), .len_i(len),
    .overlap_i(overlap), .cnt_clr_i(cnt_clr), .out_o(out_a), .match_cnt_o(cnt_a)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_c2 (
    .clock_i(clk), .sreset_ni(rst_n), .in_i(in_bit), .valid_i(valid),
    .cfg_load_i(cfg_load), .pattern_i(pattern), .len_i(len),
    .overlap_i(overlap), .cnt_clr_i(cnt_clr), .out_o(out_b), .match_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    valid  = 1'b1;
    in_bit = b;
    cyc();
    valid  = 1'b0;
    check(tag, {31'd0, out_a}, {31'd0, exp_out});
  endtask

  task automatic idle(input string tag);
    valid = 1'b0;
    cyc();
    check(tag, {31'd0, out_a}, 32'd0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_load = 1'b1;
    pattern  = p;
    len      = l;
    overlap  = o;
    cyc();
    cfg_load = 1'b0;
    check("load_out", {31'd0, out_a}, 32'd0);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_bit = 1'b0; valid = 1'b0; cfg_load = 1'b0;
    pattern = '0; len = '0; overlap = 1'b0; cnt_clr = 1'b0;
    #2;
    cyc();
    cyc();
    check("rst_out", {31'd0, out_a}, 32'd0);
    check("rst_cnt", {24'd0, cnt_a}, 32'd0);
    rst_n = 1'b1;

    // Overlapping detection of 1011 in 1011011.
    load(8'b1011, 4'd4, 1'b1);
    send(1, 0, "ovl_b1"); send(0, 0, "ovl_b2"); send(1, 0, "ovl_b3");
    send(1, 1, "ovl_b4"); send(0, 0, "ovl_b5"); send(1, 0, "ovl_b6");
    send(1, 1, "ovl_b7");
    check("ovl_cnt", {24'd0, cnt_a}, 32'd2);

    // Non-overlapping: the second occurrence shares bits and must not fire.
    clear_cnt();
    check("clr_cnt", {24'd0, cnt_a}, 32'd0);
    load(8'b1011, 4'd4, 1'b0);
    send(1, 0, "novl_b1"); send(0, 0, "novl_b2"); send(1, 0, "novl_b3");
    send(1, 1, "novl_b4"); send(0, 0, "novl_b5"); send(1, 0, "novl_b6");
    send(1, 0, "novl_b7");
    check("novl_cnt", {24'd0, cnt_a}, 32'd1);

    // Valid gaps hold history.
    clear_cnt();
    load(8'b110, 4'd3, 1'b1);
    send(1, 0, "gap_b1"); idle("gap_i1"); idle("gap_i2");
    send(1, 0, "gap_b2"); idle("gap_i3"); idle("gap_i4");
    send(0, 1, "gap_b3"); idle("gap_i5"); idle("gap_i6");
    check("gap_cnt", {24'd0, cnt_a}, 32'd1);

    // Length 0 disables detection.
    load(8'b110, 4'd0, 1'b1);
    send(1, 0, "len0_b1"); send(1, 0, "len0_b2"); send(0, 0, "len0_b3");
    check("len0_cnt", {24'd0, cnt_a}, 32'd1);

    // Reload mid-stream with a valid 1 in the load cycle, which is discarded.
    send(1, 0, "rl_b1"); send(0, 0, "rl_b2"); send(1, 0, "rl_b3");
    valid = 1'b1; in_bit = 1'b1;
    load(8'b01, 4'd2, 1'b1);
    send(0, 0, "rl_b4"); send(1, 1, "rl_b5");

    valid = 1'b1; in_bit = 1'b1;
    load(8'b11, 4'd2, 1'b1);
    send(1, 0, "disc_b1"); send(1, 1, "disc_b2");

    // Length 15 clamps to 8: only the eighth bit completes a match.
    load(8'b1011_0011, 4'd15, 1'b1);
    send(1, 0, "clamp_b1"); send(0, 0, "clamp_b2"); send(1, 0, "clamp_b3");
    send(1, 0, "clamp_b4"); send(0, 0, "clamp_b5"); send(0, 0, "clamp_b6");
    send(1, 0, "clamp_b7"); send(1, 1, "clamp_b8");
    check("clamp_cnt", {24'd0, cnt_a}, 32'd4);

    // Reset mid-stream leaves the detector disabled.
    load(8'b1011, 4'd4, 1'b1);
    send(1, 0, "rst_b1"); send(0, 0, "rst_b2"); send(1, 0, "rst_b3");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mrst_out", {31'd0, out_a}, 32'd0);
    check("mrst_cnt", {24'd0, cnt_a}, 32'd0);
    send(1, 0, "post_rst_b1"); send(0, 0, "post_rst_b2");
    send(1, 0, "post_rst_b3"); send(1, 0, "post_rst_b4");
    check("post_rst_cnt", {24'd0, cnt_a}, 32'd0);

    // Length 1, overlap: every 1 matches; the 2-bit counter saturates at 3.
    load(8'b1, 4'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(1, 1, "sat_out");
      check("sat_out_b", {31'd0, out_b}, 32'd1);
      check("sat_cnt8", {24'd0, cnt_a}, i);
      check("sat_cnt2", {30'd0, cnt_b}, (i > 3) ? 32'd3 : i);
    end
    send(0, 0, "sat_zero");

    // Clear coincident with a match: count 0, pulse still present.
    cnt_clr = 1'b1;
    send(1, 1, "clrm_out");
    cnt_clr = 1'b0;
    check("clrm_cnt8", {24'd0, cnt_a}, 32'd0);
    check("clrm_cnt2", {30'd0, cnt_b}, 32'd0);
    send(1, 1, "after_clr_out");
    check("after_clr_cnt", {24'd0, cnt_a}, 32'd1);
    idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial sequence detector, the next generation of the team's fixed-pattern detector FSM. It watches a qualified 1-bit input stream and pulses `out_o` for one cycle whenever the last `len` received bits equal a programmed pattern. Overlapping or non-overlapping detection is selectable, and a saturating match counter is included. It sits in the same serial front-end as the fixed detector and is the drop-in replacement for it.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits, minimum 2.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of the length field.
- `CNT_W`, default 8: match counter width.

Ports:
- `clock_i` in 1: single clock. All state updates on the rising edge.
- `sreset_ni` in 1: reset, synchronous, active-low. This is already decided.
- `in_i` in 1: serial data bit.
- `valid_i` in 1: `in_i` is consumed only in cycles where `valid_i` is 1.
- `cfg_load_i` in 1: latch `pattern_i`, `len_i` and `overlap_i` into the config registers.
- `pattern_i` in `MAX_LEN`: the pattern. Bit `[len-1]` is the first bit received and bit `[0]` is the last.
- `len_i` in `LEN_W`: pattern length.
- `overlap_i` in 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `cnt_clr_i` in 1: synchronous clear of `match_cnt_o`.
- `out_o` out 1: registered one-cycle match pulse.
- `match_cnt_o` out `CNT_W`: saturating count of matches.

## Operation
Internal registers:
- `hist[MAX_LEN-1:0]`: history shift register.
- `fill`: count of valid bits received since the last restart, saturating at `MAX_LEN`.
- `pat_q`, `len_q`, `ovl_q`: config registers.

On each accepted bit (`valid_i`=1, `cfg_load_i`=0):
- `hist <= {hist[MAX_LEN-2:0], in_i}`.
- `fill <= min(fill+1, MAX_LEN)`.

Match condition, evaluated on the updated history and fill:
- `len_q` is not 0, and
- `fill` is at least `len_q`, and
- `hist[len_q-1:0] == pat_q[len_q-1:0]`.

On a match:
- `out_o` is 1 in the next cycle.
- `match_cnt_o` increments, saturating at `2^CNT_W-1`.
- If `ovl_q`=0, `fill` is forced to 0 instead of incrementing, so the next match needs `len_q` fresh bits.
- If `ovl_q`=1, `fill` updates normally.

Configuration load (`cfg_load_i`=1):
- Loads the config registers.
- Clears `hist` and `fill`.
- Any `in_i` in that cycle is discarded, even if `valid_i`=1.
- `out_o` is 0 the next cycle.
- `match_cnt_o` is unchanged.

`len_i` values:
- `len_i`=0 disables the detector: it never matches, but bits still shift into `hist`.
- `len_i` greater than `MAX_LEN` is clamped to `MAX_LEN` at load.

Idle cycles (`valid_i`=0): `hist` and `fill` hold, and `out_o` is 0 the next cycle.

`cnt_clr_i` rules:
- `cnt_clr_i`=1 sets the counter to 0 on the next edge.
- If it coincides with a match, the clear wins (the count is 0), but `out_o` still pulses.

Reset (`sreset_ni`=0 at an edge):
- `hist`, `fill`, `pat_q`, `len_q` and `ovl_q` all become 0, which leaves the detector disabled.
- `out_o` becomes 0 and `match_cnt_o` becomes 0.
- Reset overrides every other input.
- Reset mid-stream discards all progress.

## Timing
- Latency: the match is seen on `out_o` one cycle after the edge that accepts the completing bit. There is no combinational path from any input to any output.
- The `out_o` pulse is exactly 1 cycle wide per match.
- Back-to-back matches with `ovl_q`=1 and `len_q`=1 produce `out_o` high on consecutive cycles.
- The new config takes effect starting with the first valid bit after the load cycle.
- Reset is sampled on `clock_i` only. Outputs reach their reset values after the first edge with `sreset_ni`=0.

## Test plan
All scenarios use `MAX_LEN`=8.

1. **Overlap.** Load pattern `4'b1011`, length 4, `overlap_i`=1. Send valid bits 1,0,1,1,0,1,1.
   - Required: `out_o` pulses after bit 4 and after bit 7.
   - `match_cnt_o`=2.
2. **Non-overlap.** Same config with `overlap_i`=0, same bits.
   - Required: a single pulse after bit 4, no pulse after bit 7.
   - `match_cnt_o`=1.
3. **Valid gaps and disabled length.** Pattern `3'b110`, length 3. Send bits 1,1,0 with `valid_i` low for 2 cycles between each bit.
   - Required: one pulse, one cycle after the third valid bit, and nothing else.
   - Then load `len_i`=0 and send 1,1,0: no pulse.
4. **Reload mid-stream and clamp.** Send 1,0,1, then `cfg_load_i` with pattern `2'b01` and length 2, with `valid_i`=1 and `in_i`=1 in the load cycle. Then send 0,1.
   - Required: no pulse from the old history; a pulse after the 1.
   - Loading `len_i`=15 behaves as length 8.
5. **Reset mid-stream.** Pattern `1011`, length 4. Send 1,0,1, then pulse `sreset_ni` low for 1 cycle.
   - Required: `out_o`=0 and `match_cnt_o`=0 after reset.
   - Sending 1 afterwards gives no match, because the detector is disabled until reloaded.
6. **Counter saturation and clear.** Set `CNT_W`=2, length 1, pattern 1, overlap on. Send 5 valid ones.
   - Required: 5 pulses, with `match_cnt_o` saturating at 3.
   - `cnt_clr_i` asserted together with a match leaves the count at 0 while `out_o` still pulses.
